// File: rtl/register_pulse_if.sv
// register_pulse_if
//   Bundles the save/load control and data bus of register_pulse.
//   Signals:
//     save_en          save request; a rising edge captures data_in
//     load_en          level output enable for data_out
//     data_in          word to be stored
//     data_out         stored word while load_en=1, zeros otherwise
//     data_out_always  stored word, unconditionally
//   Modports:
//     master  drives save_en/load_en/data_in and observes the outputs
//     slave   the register itself
interface register_pulse_if #(
  parameter int WIDTH = 8
);
  logic             save_en;
  logic             load_en;
  logic [WIDTH-1:0] data_in;
  logic [WIDTH-1:0] data_out;
  logic [WIDTH-1:0] data_out_always;

  modport master (
    output save_en,
    output load_en,
    output data_in,
    input  data_out,
    input  data_out_always
  );

  modport slave (
    input  save_en,
    input  load_en,
    input  data_in,
    output data_out,
    output data_out_always
  );
endinterface

// File: rtl/register_pulse.sv
// register_pulse
//   General-purpose datapath storage register. A word is captured once per
//   rising edge of save_en (detected against the previous clk sample), the
//   stored word is driven onto data_out only while load_en is high, and is
//   always visible on data_out_always.
//   Ports:
//     clk  system clock, rising-edge active
//     rst  synchronous active-high reset (priority over all inputs)
//     bus  register_pulse_if.slave: save_en, load_en, data_in in;
//          data_out, data_out_always out
module register_pulse #(
  parameter int               WIDTH       = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  register_pulse_if.slave       bus
);

  logic [WIDTH-1:0] stored_q;
  logic [WIDTH-1:0] stored_d;
  logic             save_q;
  logic             save_d;
  logic             save_rise;

  always_comb begin
    save_rise = bus.save_en & ~save_q;
    stored_d  = stored_q;
    save_d    = bus.save_en;
    if (save_rise) begin
      stored_d = bus.data_in;
    end
  end

  // save_q clears on reset so a save_en held high through reset release is
  // seen as a fresh rise on the first non-reset edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      stored_q <= RESET_VALUE;
      save_q   <= 1'b0;
    end else begin
      stored_q <= stored_d;
      save_q   <= save_d;
    end
  end

  // Bus output is gated to zeros (not high-Z) when not enabled.
  assign bus.data_out        = bus.load_en ? stored_q : {WIDTH{1'b0}};
  assign bus.data_out_always = stored_q;

endmodule

// File: tb/tb_register_pulse.sv
module tb_register_pulse;
  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;

  register_pulse_if #(.WIDTH(8)) bus0 ();
  register_pulse_if #(.WIDTH(8)) bus1 ();

  register_pulse #(.WIDTH(8), .RESET_VALUE(8'h00)) dut0 (
    .clk (clk),
    .rst (rst),
    .bus (bus0.slave)
  );

  register_pulse #(.WIDTH(8), .RESET_VALUE(8'hA5)) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%02h expected 0x%02h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst = 1'b1;
    bus0.save_en = 1'b0; bus0.load_en = 1'b0; bus0.data_in = 8'h00;
    bus1.save_en = 1'b0; bus1.load_en = 1'b0; bus1.data_in = 8'h00;

    // Reset, both reset values
    tick(); tick();
    chk("rst0_always", bus0.data_out_always, 8'h00);
    chk("rst0_out",    bus0.data_out,        8'h00);
    chk("rst1_always", bus1.data_out_always, 8'hA5);
    chk("rst1_out",    bus1.data_out,        8'h00);
    bus1.load_en = 1'b1; #1;
    chk("rst1_load",   bus1.data_out,        8'hA5);
    bus1.load_en = 1'b0;

    // Basic save, save_en held 5 clocks
    rst = 1'b0;
    bus0.data_in = 8'h01; bus0.save_en = 1'b1; #1;
    chk("pre_edge",    bus0.data_out_always, 8'h00);
    tick();
    chk("save01",      bus0.data_out_always, 8'h01);
    chk("save01_out",  bus0.data_out,        8'h00);
    for (int i = 0; i < 4; i++) tick();
    chk("save01_hold", bus0.data_out_always, 8'h01);
    bus0.save_en = 1'b0;
    bus0.load_en = 1'b1; #1;
    chk("load01",      bus0.data_out,        8'h01);
    bus0.load_en = 1'b0; #1;
    chk("unload01",    bus0.data_out,        8'h00);

    // Second word
    tick();
    bus0.data_in = 8'h03; bus0.save_en = 1'b1;
    tick();
    bus0.save_en = 1'b0;
    chk("save03",      bus0.data_out_always, 8'h03);
    bus0.load_en = 1'b1; #1;
    chk("load03",      bus0.data_out,        8'h03);
    tick(); tick();
    chk("load03_rep",  bus0.data_out,        8'h03);
    bus0.load_en = 1'b0; #1;
    chk("unload03",    bus0.data_out,        8'h00);

    // One capture per pulse while data_in steps
    tick();
    bus0.data_in = 8'h10; bus0.save_en = 1'b1;
    tick();
    chk("sc_10",       bus0.data_out_always, 8'h10);
    bus0.data_in = 8'h20;
    tick();
    chk("sc_20_ign",   bus0.data_out_always, 8'h10);
    bus0.data_in = 8'h30;
    tick();
    chk("sc_30_ign",   bus0.data_out_always, 8'h10);
    bus0.save_en = 1'b0;
    tick();
    chk("sc_drop",     bus0.data_out_always, 8'h10);
    bus0.save_en = 1'b1;
    tick();
    chk("sc_reraise",  bus0.data_out_always, 8'h30);
    bus0.save_en = 1'b0;
    tick();

    // Save and load together
    bus0.data_in = 8'h55; bus0.save_en = 1'b1;
    tick();
    bus0.save_en = 1'b0;
    tick();
    bus0.load_en = 1'b1; bus0.data_in = 8'hAA; bus0.save_en = 1'b1; #1;
    chk("sl_before",   bus0.data_out,        8'h55);
    tick();
    chk("sl_after",    bus0.data_out,        8'hAA);
    bus0.save_en = 1'b0; bus0.load_en = 1'b0;
    tick();

    // Reset mid-pulse, then fresh capture after release
    bus0.data_in = 8'h7E; bus0.save_en = 1'b1;
    tick();
    bus0.save_en = 1'b0;
    chk("mid_7e",      bus0.data_out_always, 8'h7E);
    tick();
    bus0.data_in = 8'h42; bus0.save_en = 1'b1; rst = 1'b1;
    bus1.data_in = 8'h42; bus1.save_en = 1'b1;
    tick();
    chk("mid_rst0",    bus0.data_out_always, 8'h00);
    chk("mid_rst1",    bus1.data_out_always, 8'hA5);
    rst = 1'b0;
    tick();
    chk("rel_cap0",    bus0.data_out_always, 8'h42);
    chk("rel_cap1",    bus1.data_out_always, 8'h42);
    bus0.data_in = 8'h99; bus1.data_in = 8'h99;
    tick(); tick();
    chk("rel_once0",   bus0.data_out_always, 8'h42);
    chk("rel_once1",   bus1.data_out_always, 8'h42);
    bus0.save_en = 1'b0; bus1.save_en = 1'b0;
    tick();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
